apb_bridge_fsm: RTL
===================

// Module: apb_bridge_fsm
// PURPOSE
//  Sequencing controller of the AHB-to-APB bridge: accepts one AHB-Lite transfer at a time, decodes the slave index,
//  and drives the APB master port through IDLE->SETUP->ACCESS.
//  Stalls AHB via Hreadyout; returns read data and an OKAY/ERROR response. Sits between the AHB slave interface and the apb master port.
// PARAMETERS
//  SEL_LSB   28  Haddr bit position of the slave-index field
//  SEL_BITS  2   width of slave-index field; index >= `SLAVES is unmapped
//  (`WIDTH, `SLAVES come from definitions.v)
// PORTS
//  Hclk        in   1          bridge clock, rising edge
//  Hresetn     in   1          asynchronous active-low reset
//  Hsel        in   1          bridge selected by AHB decoder
//  Hready_in   in   1          AHB bus ready (previous data phase done)
//  Htrans      in   2          AHB transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
//  Hwrite      in   1          1 = write
//  Haddr       in   `WIDTH     AHB address
//  Hwdata      in   `WIDTH     AHB write data (valid in data phase)
//  Hreadyout   out  1          registered; 0 stalls AHB data phase
//  Hresp       out  2          registered; 00 OKAY, 01 ERROR
//  Hrdata      out  `WIDTH     registered read data
//  Paddr_in    out  `WIDTH     APB address, held from SETUP through ACCESS
//  Pwrite_in   out  1          APB direction
//  Penable_in  out  1          APB enable (ACCESS phase)
//  Pwdata_in   out  `WIDTH     APB write data
//  Pselx_in    out  `SLAVES    one-hot APB select
//  Prdata_in   in   `WIDTH     APB read data (from apb master port)
//  Pready      in   1          APB slave ready; present only with APB_PREADY_EN
// BEHAVIOUR
//  Reset (async, Hresetn=0): state IDLE; Hreadyout=1, Hresp=00, Hrdata=0, Paddr_in=0, Pwrite_in=0,
//   Penable_in=0, Pwdata_in=0, Pselx_in=0. Reset mid-transfer aborts immediately; no APB completion.
//  valid = Hsel & Hready_in & Htrans[1]; sampled only in IDLE and ERR2 (Hreadyout=1). BUSY/IDLE Htrans ignored.
//  idx = Haddr[SEL_LSB+SEL_BITS-1:SEL_LSB]; mapped iff idx < `SLAVES.
//  States (all outputs registered, Moore):
//   IDLE:   Hreadyout=1. valid&unmapped->ERR1; valid&write->WWAIT (latch Haddr, Hwrite, idx); valid&read->SETUP (latch).
//   WWAIT:  Hreadyout=0; capture Hwdata into Pwdata_in; ->SETUP.
//   SETUP:  Pselx_in=1<<idx, Penable_in=0, Paddr_in/Pwrite_in valid; Hreadyout=0; ->ACCESS.
//   ACCESS: Penable_in=1, Pselx_in held; Hreadyout=0. Completion: on read, Hrdata<=Prdata_in; ->IDLE.
//   ERR1:   Hresp=01, Hreadyout=0, no APB activity; ->ERR2.
//   ERR2:   Hresp=01, Hreadyout=1; accepts new transfer exactly as IDLE, else ->IDLE.
//  On leaving ACCESS: Pselx_in=0, Penable_in=0; Paddr_in/Pwdata_in hold last value.
//  Latency (no wait): read addr sampled T0 -> SETUP T1, ACCESS T2, Hreadyout=1 + Hrdata valid T3.
//   Write: T0 addr, T1 WWAIT, T2 SETUP, T3 ACCESS, T4 Hreadyout=1.
//  Back-to-back: transfer sampled in IDLE/ERR2 cycle; min one IDLE cycle between APB transfers (no SETUP-after-ACCESS merge).
//  Hresp returns to 00 in every state except ERR1/ERR2.
// CONFIGURATION
//  APB_PREADY_EN defined: Pready port exists; ACCESS repeats while Pready=0, completes on Pready=1; signals held stable.
//  Undefined: no Pready port; ACCESS lasts exactly one cycle.
// STRUCTURE
//  definitions.v: state encodings (ST_IDLE, ST_WWAIT, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2), HTRANS_* and HRESP_* codes.
//  Sub-module apb_sel_decode: combinational idx -> one-hot Pselx + mapped flag.
// TESTING
//  1 Read: Haddr=0x1000_0010, Htrans=10, Hwrite=0, Prdata_in=0xDEADBEEF -> Pselx_in=0010 T1, Penable_in=1 T2, Hrdata=0xDEADBEEF, Hreadyout=1 T3.
//  2 Write: Haddr=0x2000_0004, Hwdata=0xA5A5_0001 at T1 -> Pselx_in=0100, Pwrite_in=1, Pwdata_in=0xA5A5_0001 T2..T3, Hreadyout=1 T4.
//  3 Unmapped (SLAVES=3): Haddr=0x3000_0000 -> Hresp=01/Hreadyout=0 T1, Hresp=01/Hreadyout=1 T2, Pselx_in stays 0.
//  4 Htrans=01 or 00, or Hsel=0, or Hready_in=0 -> stays IDLE, no Pselx_in activity.
//  5 APB_PREADY_EN, Pready low 3 cycles in ACCESS -> Penable_in=1 for 4 cycles, Paddr_in stable, Hreadyout=1 one cycle after Pready=1.
//  6 Hresetn=0 during ACCESS -> same-cycle async: Penable_in=0, Pselx_in=0, Hreadyout=1; next valid read completes normally.

Source files
------------

// File: rtl/apb_bridge_fsm_pkg.sv
// Shared types and constants for the AHB-to-APB bridge sequencer.
// Bus width, slave count, state encodings and AHB transfer/response codes.
package apb_bridge_fsm_pkg;

  localparam int WIDTH  = 32;
  localparam int SLAVES = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WWAIT  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/apb_sel_decode.sv
// Combinational slave-index decoder: one-hot APB select plus a mapped flag
// for indices below the number of populated slaves.
module apb_sel_decode #(
  parameter int SEL_BITS = 2,
  parameter int NSLV     = 3
) (
  input  logic [SEL_BITS-1:0] idx_i,
  output logic [NSLV-1:0]     sel_o,
  output logic                mapped_o
);

  always_comb begin
    sel_o = '0;
    for (int i = 0; i < NSLV; i++) begin
      sel_o[i] = (idx_i == SEL_BITS'(i));
    end
    mapped_o = (int'(idx_i) < NSLV);
  end

endmodule

// File: rtl/apb_bridge_fsm.sv
// AHB-Lite to APB bridge sequencer: one transfer at a time through IDLE/SETUP/ACCESS.
// Optional APB_PREADY_EN adds a Pready input that stretches the ACCESS phase.
module apb_bridge_fsm
  import apb_bridge_fsm_pkg::*;
#(
  parameter int SEL_LSB  = 28,
  parameter int SEL_BITS = 2
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              Hsel,
  input  logic              Hready_in,
  input  logic [1:0]        Htrans,
  input  logic              Hwrite,
  input  logic [WIDTH-1:0]  Haddr,
  input  logic [WIDTH-1:0]  Hwdata,
  output logic              Hreadyout,
  output logic [1:0]        Hresp,
  output logic [WIDTH-1:0]  Hrdata,
  output logic [WIDTH-1:0]  Paddr_in,
  output logic              Pwrite_in,
  output logic              Penable_in,
  output logic [WIDTH-1:0]  Pwdata_in,
  output logic [SLAVES-1:0] Pselx_in,
  input  logic [WIDTH-1:0]  Prdata_in
`ifdef APB_PREADY_EN
  ,
  input  logic              Pready
`endif
);

  state_t             state_q, state_d;
  logic               hready_q, hready_d;
  logic [1:0]         hresp_q, hresp_d;
  logic [WIDTH-1:0]   hrdata_q, hrdata_d;
  logic [WIDTH-1:0]   paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic               penable_q, penable_d;
  logic [WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [SLAVES-1:0]  psel_q, psel_d;
  logic [SLAVES-1:0]  slv_q, slv_d;

  logic               valid;
  logic               mapped;
  logic               access_done;
  logic [SLAVES-1:0]  dec_sel;

  apb_sel_decode #(
    .SEL_BITS (SEL_BITS),
    .NSLV     (SLAVES)
  ) u_sel_decode (
    .idx_i    (Haddr[SEL_LSB+SEL_BITS-1:SEL_LSB]),
    .sel_o    (dec_sel),
    .mapped_o (mapped)
  );

  assign valid = Hsel & Hready_in & htrans_active(Htrans);

`ifdef APB_PREADY_EN
  assign access_done = Pready;
`else
  assign access_done = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    hrdata_d = hrdata_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    slv_d    = slv_q;

    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (valid) begin
          if (!mapped) begin
            state_d = ST_ERR1;
          end else begin
            paddr_d  = Haddr;
            pwrite_d = Hwrite;
            slv_d    = dec_sel;
            state_d  = Hwrite ? ST_WWAIT : ST_SETUP;
          end
        end
      end
      ST_WWAIT: begin
        pwdata_d = Hwdata;
        state_d  = ST_SETUP;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (access_done) begin
          state_d = ST_IDLE;
          if (!pwrite_q) hrdata_d = Prdata_in;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so every one leaves a flop (Moore, registered).
    hready_d  = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d   = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    penable_d = (state_d == ST_ACCESS);
    psel_d    = ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) ? slv_d : '0;
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= ST_IDLE;
      hready_q  <= 1'b1;
      hresp_q   <= HRESP_OKAY;
      hrdata_q  <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      slv_q     <= '0;
    end else begin
      state_q   <= state_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
      hrdata_q  <= hrdata_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      slv_q     <= slv_d;
    end
  end

  assign Hreadyout  = hready_q;
  assign Hresp      = hresp_q;
  assign Hrdata     = hrdata_q;
  assign Paddr_in   = paddr_q;
  assign Pwrite_in  = pwrite_q;
  assign Penable_in = penable_q;
  assign Pwdata_in  = pwdata_q;
  assign Pselx_in   = psel_q;

endmodule
